parking_session_ctrl: RTL and testbench

//  Sequences the shared free-running parking timer among the entry gate and the exit gate.
//  - Entry: allocates the lowest free slot and timestamps it with the current timer value.
//  - Exit: releases the slot and reports the stay duration (timer now - timestamp, wrapping).
//  - Arbitration: round-robin between the gates; one session operation per grant.

---
 rtl/parking_pkg.sv | 20 ++
 rtl/slot_priority_encoder.sv | 23 ++
 rtl/parking_session_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_parking_session_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and constants for the parking session controller:
// FSM state encoding, gate identifiers and default widths.
package parking_pkg;

  localparam int SLOTS_DEFAULT = 8;
  localparam int TW_DEFAULT    = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    EXIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic {
    ENTRY_GATE = 1'b0,
    EXIT_GATE  = 1'b1
  } gate_e;

endpackage

// File: rtl/slot_priority_encoder.sv
// Combinational lowest-index finder over the free-slot mask.
module slot_priority_encoder #(
  parameter int SLOTS  = 8,
  parameter int SLOT_W = 3
) (
  input  logic [SLOTS-1:0]  free_mask,
  output logic [SLOT_W-1:0] free_idx,
  output logic              any_free
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    free_idx = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (free_mask[i]) begin
        free_idx = SLOT_W'(i);
      end
    end
  end

  assign any_free = |free_mask;

endmodule

// File: rtl/parking_session_ctrl.sv
// Arbitrates entry/exit gates onto the shared timer, allocating slots with
// timestamps on entry and reporting wrapped stay durations on exit.
module parking_session_ctrl
  import parking_pkg::*;
#(
  parameter int SLOTS  = SLOTS_DEFAULT,
  parameter int SLOT_W = 3,
  parameter int TW     = TW_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [TW-1:0]     timer,
  input  logic              entry_req,
  output logic              entry_ack,
  output logic [SLOT_W-1:0] entry_slot,
  output logic              entry_full,
  input  logic              exit_req,
  input  logic [SLOT_W-1:0] exit_slot,
  output logic              exit_ack,
  output logic [TW-1:0]     exit_duration,
  output logic              exit_err,
  output logic [SLOTS-1:0]  occupancy,
  output logic [SLOT_W:0]   free_count,
  output logic              full,
  output logic              empty
);

  localparam int CNT_W = SLOT_W + 1;

  state_e            state_q, state_d;
  gate_e             rr_last_q, rr_last_d;
  logic [SLOTS-1:0]  occ_q, occ_d;
  logic [TW-1:0]     ts_q [SLOTS];
  logic [TW-1:0]     ts_d [SLOTS];
  logic [SLOT_W-1:0] entry_slot_q, entry_slot_d;
  logic              entry_full_q, entry_full_d;
  logic [TW-1:0]     exit_dur_q, exit_dur_d;
  logic              exit_err_q, exit_err_d;
  logic              entry_ack_q, entry_ack_d;
  logic              exit_ack_q, exit_ack_d;
  logic [CNT_W-1:0]  free_count_q, free_count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;

  logic [SLOT_W-1:0] free_idx;
  logic              any_free;
  logic              exit_in_range;
  logic              exit_hit;
  logic [CNT_W-1:0]  occ_cnt;

  slot_priority_encoder #(
    .SLOTS  (SLOTS),
    .SLOT_W (SLOT_W)
  ) u_prio (
    .free_mask (~occ_q),
    .free_idx  (free_idx),
    .any_free  (any_free)
  );

  assign exit_in_range = (32'(exit_slot) < 32'(SLOTS));
  assign exit_hit      = exit_in_range && occ_q[exit_slot];

  always_comb begin
    state_d      = state_q;
    rr_last_d    = rr_last_q;
    occ_d        = occ_q;
    ts_d         = ts_q;
    entry_slot_d = entry_slot_q;
    entry_full_d = entry_full_q;
    exit_dur_d   = exit_dur_q;
    exit_err_d   = exit_err_q;
    entry_ack_d  = 1'b0;
    exit_ack_d   = 1'b0;

    case (state_q)
      IDLE: begin
        // rr_last only moves on contested grants, so alternation is per conflict.
        if (entry_req && exit_req) begin
          if (rr_last_q == EXIT_GATE) begin
            state_d   = ENTRY;
            rr_last_d = ENTRY_GATE;
          end else begin
            state_d   = EXIT;
            rr_last_d = EXIT_GATE;
          end
        end else if (entry_req) begin
          state_d = ENTRY;
        end else if (exit_req) begin
          state_d = EXIT;
        end
      end
      ENTRY: begin
        state_d     = DONE;
        entry_ack_d = 1'b1;
        if (any_free) begin
          occ_d[free_idx] = 1'b1;
          ts_d[free_idx]  = timer;
          entry_slot_d    = free_idx;
          entry_full_d    = 1'b0;
        end else begin
          entry_full_d = 1'b1;
        end
      end
      EXIT: begin
        state_d    = DONE;
        exit_ack_d = 1'b1;
        if (exit_hit) begin
          exit_dur_d       = timer - ts_q[exit_slot];
          occ_d[exit_slot] = 1'b0;
          exit_err_d       = 1'b0;
        end else begin
          exit_dur_d = '0;
          exit_err_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    occ_cnt = '0;
    for (int i = 0; i < SLOTS; i++) begin
      occ_cnt = occ_cnt + {{SLOT_W{1'b0}}, occ_d[i]};
    end
    free_count_d = CNT_W'(SLOTS) - occ_cnt;
    full_d       = (free_count_d == '0);
    empty_d      = (free_count_d == CNT_W'(SLOTS));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_last_q    <= EXIT_GATE;
      occ_q        <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        ts_q[i] <= '0;
      end
      entry_slot_q <= '0;
      entry_full_q <= 1'b0;
      exit_dur_q   <= '0;
      exit_err_q   <= 1'b0;
      entry_ack_q  <= 1'b0;
      exit_ack_q   <= 1'b0;
      free_count_q <= CNT_W'(SLOTS);
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      rr_last_q    <= rr_last_d;
      occ_q        <= occ_d;
      ts_q         <= ts_d;
      entry_slot_q <= entry_slot_d;
      entry_full_q <= entry_full_d;
      exit_dur_q   <= exit_dur_d;
      exit_err_q   <= exit_err_d;
      entry_ack_q  <= entry_ack_d;
      exit_ack_q   <= exit_ack_d;
      free_count_q <= free_count_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
    end
  end

  assign entry_ack     = entry_ack_q;
  assign entry_slot    = entry_slot_q;
  assign entry_full    = entry_full_q;
  assign exit_ack      = exit_ack_q;
  assign exit_duration = exit_dur_q;
  assign exit_err      = exit_err_q;
  assign occupancy     = occ_q;
  assign free_count    = free_count_q;
  assign full          = full_q;
  assign empty         = empty_q;

endmodule

// File: tb/tb_parking_session_ctrl.sv
// Scoreboard bench: a slot/timestamp array model predicts every gate response;
// a negedge monitor pops predictions and compares whenever an ack appears.
module tb_parking_session_ctrl;

  localparam int SLOTS  = 8;
  localparam int SLOT_W = 3;
  localparam int TW     = 11;
  localparam int TMOD   = 1 << TW;

  logic              clk = 1'b0;
  logic              reset;
  logic [TW-1:0]     timer;
  logic              entry_req;
  logic              entry_ack;
  logic [SLOT_W-1:0] entry_slot;
  logic              entry_full;
  logic              exit_req;
  logic [SLOT_W-1:0] exit_slot;
  logic              exit_ack;
  logic [TW-1:0]     exit_duration;
  logic              exit_err;
  logic [SLOTS-1:0]  occupancy;
  logic [SLOT_W:0]   free_count;
  logic              full;
  logic              empty;

  always #5 clk = ~clk;

  parking_session_ctrl #(
    .SLOTS  (SLOTS),
    .SLOT_W (SLOT_W),
    .TW     (TW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .timer         (timer),
    .entry_req     (entry_req),
    .entry_ack     (entry_ack),
    .entry_slot    (entry_slot),
    .entry_full    (entry_full),
    .exit_req      (exit_req),
    .exit_slot     (exit_slot),
    .exit_ack      (exit_ack),
    .exit_duration (exit_duration),
    .exit_err      (exit_err),
    .occupancy     (occupancy),
    .free_count    (free_count),
    .full          (full),
    .empty         (empty)
  );

  typedef struct {
    bit is_entry;
    int entry_slot;
    bit entry_full;
    int dur;
    bit err;
    int occ;
    int free_cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain arrays of slot flags and entry times.
  bit m_occ[SLOTS];
  int m_ts[SLOTS];
  int m_last_winner;
  int m_entry_slot;
  bit m_entry_full;
  int m_dur;
  bit m_err;

  task automatic checkOutput(string name, int act, int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  function automatic int modelOccWord();
    int w = 0;
    for (int i = 0; i < SLOTS; i++) if (m_occ[i]) w |= (1 << i);
    return w;
  endfunction

  function automatic int modelFree();
    int n = 0;
    for (int i = 0; i < SLOTS; i++) if (!m_occ[i]) n++;
    return n;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < SLOTS; i++) begin
      m_occ[i] = 1'b0;
      m_ts[i]  = 0;
    end
    m_last_winner = 1;
    m_entry_slot  = 0;
    m_entry_full  = 1'b0;
    m_dur         = 0;
    m_err         = 1'b0;
    exp_q.delete();
  endtask

  task automatic pushSnapshot(bit is_entry);
    exp_t e;
    e.is_entry   = is_entry;
    e.entry_slot = m_entry_slot;
    e.entry_full = m_entry_full;
    e.dur        = m_dur;
    e.err        = m_err;
    e.occ        = modelOccWord();
    e.free_cnt   = modelFree();
    exp_q.push_back(e);
  endtask

  task automatic modelEntry(int t);
    int idx = -1;
    for (int i = 0; i < SLOTS; i++) if (!m_occ[i] && idx < 0) idx = i;
    if (idx < 0) begin
      m_entry_full = 1'b1;
    end else begin
      m_occ[idx]   = 1'b1;
      m_ts[idx]    = t;
      m_entry_slot = idx;
      m_entry_full = 1'b0;
    end
    pushSnapshot(1'b1);
  endtask

  task automatic modelExit(int s, int t);
    if (s < SLOTS && m_occ[s]) begin
      m_dur    = (t - m_ts[s] + TMOD) % TMOD;
      m_occ[s] = 1'b0;
      m_err    = 1'b0;
    end else begin
      m_dur = 0;
      m_err = 1'b1;
    end
    pushSnapshot(1'b0);
  endtask

  // One gate operation (or a simultaneous pair), with timer held for its duration.
  task automatic applyStimulus(bit do_entry, bit do_exit, int slot, int t);
    bit ent_pend, ext_pend;
    int nacks = 0;
    @(negedge clk);
    timer     = TW'(t);
    exit_slot = SLOT_W'(slot);
    if (do_entry && do_exit) begin
      if (m_last_winner == 1) begin
        m_last_winner = 0;
        modelEntry(t);
        modelExit(slot, t);
      end else begin
        m_last_winner = 1;
        modelExit(slot, t);
        modelEntry(t);
      end
    end else if (do_entry) begin
      modelEntry(t);
    end else if (do_exit) begin
      modelExit(slot, t);
    end
    ent_pend  = do_entry;
    ext_pend  = do_exit;
    entry_req = do_entry;
    exit_req  = do_exit;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (entry_ack && ent_pend) begin
        ent_pend  = 1'b0;
        entry_req = 1'b0;
        nacks++;
        checkOutput(nacks == 1 ? "ack_latency_first" : "ack_latency_second", k, nacks == 1 ? 2 : 5);
      end
      if (exit_ack && ext_pend) begin
        ext_pend = 1'b0;
        exit_req = 1'b0;
        nacks++;
        checkOutput(nacks == 1 ? "ack_latency_first" : "ack_latency_second", k, nacks == 1 ? 2 : 5);
      end
      if (!ent_pend && !ext_pend) break;
    end
    checkOutput("acks_received", int'(ent_pend || ext_pend), 0);
    entry_req = 1'b0;
    exit_req  = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset     = 1'b1;
    entry_req = 1'b0;
    exit_req  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    modelReset();
  endtask

  task automatic checkResetState();
    checkOutput("rst_occupancy", int'(occupancy), 0);
    checkOutput("rst_free_count", int'(free_count), SLOTS);
    checkOutput("rst_empty", int'(empty), 1);
    checkOutput("rst_full", int'(full), 0);
    checkOutput("rst_acks", int'({entry_ack, exit_ack}), 0);
    checkOutput("rst_flags", int'({entry_full, exit_err}), 0);
    checkOutput("rst_entry_slot", int'(entry_slot), 0);
    checkOutput("rst_exit_duration", int'(exit_duration), 0);
  endtask

  // Monitor: every ack consumes exactly one prediction.
  always @(negedge clk) begin
    if (!reset && (entry_ack || exit_ack)) begin
      checkOutput("single_ack", int'(entry_ack && exit_ack), 0);
      checkOutput("ack_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        checkOutput("ack_gate", int'(entry_ack), int'(mon_e.is_entry));
        checkOutput("entry_full", int'(entry_full), int'(mon_e.entry_full));
        if (!mon_e.entry_full) checkOutput("entry_slot", int'(entry_slot), mon_e.entry_slot);
        checkOutput("exit_err", int'(exit_err), int'(mon_e.err));
        checkOutput("exit_duration", int'(exit_duration), mon_e.dur);
        checkOutput("occupancy", int'(occupancy), mon_e.occ);
        checkOutput("free_count", int'(free_count), mon_e.free_cnt);
        checkOutput("full", int'(full), int'(mon_e.free_cnt == 0));
        checkOutput("empty", int'(empty), int'(mon_e.free_cnt == SLOTS));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int occ_list[$];
    int s;
    reset     = 1'b1;
    timer     = '0;
    entry_req = 1'b0;
    exit_req  = 1'b0;
    exit_slot = '0;
    modelReset();
    doReset();
    checkResetState();
    repeat (3) @(negedge clk);
    checkOutput("idle_no_acks", int'({entry_ack, exit_ack}), 0);

    $display("[TB] sequential entries");
    applyStimulus(1'b1, 1'b0, 0, 100);
    checkOutput("first_entry_slot", int'(entry_slot), 0);
    applyStimulus(1'b1, 1'b0, 0, 104);
    checkOutput("second_entry_slot", int'(entry_slot), 1);
    checkOutput("free_after_two", int'(free_count), 6);

    $display("[TB] wrapping duration");
    doReset();
    applyStimulus(1'b1, 1'b0, 0, 2040);
    applyStimulus(1'b0, 1'b1, 0, 5);
    checkOutput("exit_duration_wrap", int'(exit_duration), 13);
    checkOutput("slot0_freed", int'(occupancy[0]), 0);

    $display("[TB] full lot and bad release");
    doReset();
    for (int i = 0; i < SLOTS; i++) applyStimulus(1'b1, 1'b0, 0, 10 * i + 1);
    applyStimulus(1'b1, 1'b0, 0, 300);
    checkOutput("entry_full_flag", int'(entry_full), 1);
    checkOutput("occupancy_all", int'(occupancy), 8'hFF);
    applyStimulus(1'b0, 1'b1, 3, 400);
    applyStimulus(1'b0, 1'b1, 3, 410);
    checkOutput("exit_err_empty_slot", int'(exit_err), 1);

    $display("[TB] simultaneous requests");
    doReset();
    applyStimulus(1'b1, 1'b1, 2, 50);
    applyStimulus(1'b1, 1'b1, 0, 60);
    checkOutput("rr_exit_first_duration", int'(exit_duration), 10);

    $display("[TB] reset during entry");
    doReset();
    @(negedge clk);
    timer     = TW'(7);
    entry_req = 1'b1;
    @(negedge clk);
    reset     = 1'b1;
    entry_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    checkOutput("abort_occupancy", int'(occupancy), 0);
    checkOutput("abort_free_count", int'(free_count), SLOTS);
    checkOutput("abort_ack", int'(entry_ack), 0);
    repeat (2) @(negedge clk);
    checkOutput("abort_no_late_ack", int'({entry_ack, exit_ack}), 0);
    applyStimulus(1'b1, 1'b0, 0, 9);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 200; n++) begin
      int kind = $urandom_range(0, 9);
      int t    = $urandom_range(0, TMOD - 1);
      occ_list.delete();
      for (int i = 0; i < SLOTS; i++) if (m_occ[i]) occ_list.push_back(i);
      if (occ_list.size() > 0 && $urandom_range(0, 3) != 0)
        s = occ_list[$urandom_range(0, occ_list.size() - 1)];
      else
        s = $urandom_range(0, SLOTS - 1);
      if (kind < 4)      applyStimulus(1'b1, 1'b0, s, t);
      else if (kind < 8) applyStimulus(1'b0, 1'b1, s, t);
      else               applyStimulus(1'b1, 1'b1, s, t);
    end

    repeat (4) @(negedge clk);
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
